// File: rtl/keypad_event_queue_pkg.sv
// Shared types for the keypad event queue: event word layout, FSM states,
// and the one-hot decoder used when a key press is captured.
package keypad_event_queue_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int EVT_W      = 6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } kp_state_e;

  // Event word as stored in the FIFO: {repeat, release, code}.
  typedef struct packed {
    logic                  is_rep;
    logic                  is_rel;
    logic [KEY_CODE_W-1:0] code;
  } kp_evt_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } onehot_dec_t;

  // Position of the single set bit; ok=0 when the vector is not exactly one-hot.
  function automatic onehot_dec_t decode_onehot(input logic [3:0] v);
    onehot_dec_t d;
    d = '0;
    case (v)
      4'b0001: d = '{ok: 1'b1, idx: 2'd0};
      4'b0010: d = '{ok: 1'b1, idx: 2'd1};
      4'b0100: d = '{ok: 1'b1, idx: 2'd2};
      4'b1000: d = '{ok: 1'b1, idx: 2'd3};
      default: d = '{ok: 1'b0, idx: 2'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_event_queue_if.sv
// Valid/ready event port between the queue (master) and the UI/CPU (slave).
interface keypad_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_release;
  logic       evt_repeat;

  modport master (
    output evt_valid, evt_code, evt_release, evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_release, evt_repeat,
    output evt_ready
  );
endinterface

// File: rtl/keypad_event_queue_fifo.sv
// Show-ahead FIFO with wrap-bit pointers. Pure storage: a push while full is
// honoured only when a pop frees the head slot in the same cycle; any other
// drop policy belongs to the caller.
module keypad_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  // Pointer update on accepted push/pop.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad event queue: turns the poller's qualified key flag into press /
// auto-repeat / release events, queues them and hands them out over a
// valid/ready port.
module keypad_event_queue
  import keypad_event_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REPEAT_TICKS = 0,
  parameter int REPEAT_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           kp_col_in,
  input  logic [3:0]           kp_row_in,
  input  logic                 kp_pressed,
  keypad_event_queue_if.master evt,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 bad_key
);

  localparam int REP_LOAD_FIRST = (REPEAT_TICKS != 0) ? REPEAT_FIRST + REPEAT_TICKS - 1 : 0;
  localparam int REP_LOAD_NEXT  = (REPEAT_TICKS != 0) ? REPEAT_TICKS - 1 : 0;
  localparam int CNT_W          = (REP_LOAD_FIRST > 1) ? $clog2(REP_LOAD_FIRST + 1) : 1;

  kp_state_e             state;
  logic [KEY_CODE_W-1:0] code_q;
  logic [CNT_W-1:0]      rep_cnt;
  logic                  kp_q;
  logic                  rise, fall;
  onehot_dec_t           row_dec, col_dec;
  logic                  key_ok;

  logic    push_req, pop, full, empty, drop;
  kp_evt_t push_evt, head;

  assign rise    = kp_pressed && !kp_q;
  assign fall    = !kp_pressed && kp_q;
  assign row_dec = decode_onehot(kp_row_in);
  assign col_dec = decode_onehot(kp_col_in);
  assign key_ok  = row_dec.ok && col_dec.ok;

  assign pop  = evt.evt_valid && evt.evt_ready;
  assign drop = push_req && full && !pop;

  // Event to enqueue this cycle; release wins over a due repeat.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_req = 1'b0;
    push_evt = '0;
    case (state)
      S_IDLE: begin
        if (rise && key_ok) begin
          push_req = 1'b1;
          push_evt = '{is_rep: 1'b0, is_rel: 1'b0, code: {row_dec.idx, col_dec.idx}};
        end
      end
      S_HELD: begin
        if (fall) begin
          push_req = 1'b1;
          push_evt = '{is_rep: 1'b0, is_rel: 1'b1, code: code_q};
        end else if (REPEAT_TICKS != 0 && rep_cnt == '0) begin
          push_req = 1'b1;
          push_evt = '{is_rep: 1'b1, is_rel: 1'b0, code: code_q};
        end
      end
      default: ;
    endcase
  end

  // Press/hold FSM with repeat counter. It advances whether or not the FIFO
  // accepted the event, so a dropped press still produces a release attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      code_q  <= '0;
      rep_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise && key_ok) begin
            state   <= S_HELD;
            code_q  <= {row_dec.idx, col_dec.idx};
            rep_cnt <= CNT_W'(REP_LOAD_FIRST);
          end
        end
        S_HELD: begin
          if (fall) begin
            state <= S_IDLE;
          end else if (REPEAT_TICKS != 0) begin
            if (rep_cnt == '0) rep_cnt <= CNT_W'(REP_LOAD_NEXT);
            else               rep_cnt <= rep_cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Edge-detect register, sticky overflow (a new drop beats the clear), bad-key pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_q     <= 1'b0;
      overflow <= 1'b0;
      bad_key  <= 1'b0;
    end else begin
      kp_q    <= kp_pressed;
      bad_key <= rise && (state == S_IDLE) && !key_ok;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  keypad_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .pop     (pop),
    .wr_data (push_evt),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Head outputs read as zero while the queue is empty.
  assign evt.evt_valid   = !empty;
  assign evt.evt_code    = empty ? '0 : head.code;
  assign evt.evt_release = !empty && head.is_rel;
  assign evt.evt_repeat  = !empty && head.is_rep;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue with DEPTH=8, REPEAT_TICKS=5,
// REPEAT_FIRST=10. Event words are {repeat, release, code}.
module tb_keypad_event_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] kp_col_in = '0;
  logic [3:0] kp_row_in = '0;
  logic       kp_pressed = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       overflow, bad_key;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];

  keypad_event_queue_if ev();

  keypad_event_queue #(
    .DEPTH        (8),
    .REPEAT_TICKS (5),
    .REPEAT_FIRST (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kp_col_in  (kp_col_in),
    .kp_row_in  (kp_row_in),
    .kp_pressed (kp_pressed),
    .evt        (ev),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .bad_key    (bad_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] head_word();
    return 32'({ev.evt_repeat, ev.evt_release, ev.evt_code});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [3:0] col, input logic [3:0] row);
    kp_col_in = col;
    kp_row_in = row;
  endtask

  // Press for `hold` edges, then release for `gap` edges.
  task automatic press_release(input logic [3:0] col, input logic [3:0] row,
                               input int hold, input int gap);
    set_key(col, row);
    kp_pressed = 1'b1;
    repeat (hold) tick();
    kp_pressed = 1'b0;
    repeat (gap) tick();
  endtask

  // Pop every expected word in order, then confirm the queue is empty.
  task automatic drain(input string tag);
    logic [5:0] e;
    int i;
    i = 0;
    ev.evt_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s valid[%0d]", tag, i), 32'(ev.evt_valid), 32'd1);
      check($sformatf("%s head[%0d]", tag, i), head_word(), 32'(e));
      tick();
      i++;
    end
    ev.evt_ready = 1'b0;
    check($sformatf("%s empty", tag), 32'(ev.evt_valid), 32'd0);
  endtask

  int         log_t[8];
  logic [5:0] log_e[8];
  int         n_log;

  initial begin
    ev.evt_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst valid", 32'(ev.evt_valid), 32'd0);
    check("rst code", 32'(ev.evt_code), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst bad_key", 32'(bad_key), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single press/release, consumer always ready, code 0x6
    ev.evt_ready = 1'b1;
    set_key(4'b0100, 4'b0010);
    kp_pressed = 1'b1;
    tick();
    check("t1 press valid", 32'(ev.evt_valid), 32'd1);
    check("t1 press word", head_word(), 32'h06);
    tick();
    check("t1 popped", 32'(ev.evt_valid), 32'd0);
    repeat (8) tick();
    kp_pressed = 1'b0;
    tick();
    check("t1 release valid", 32'(ev.evt_valid), 32'd1);
    check("t1 release word", head_word(), 32'h16);
    tick();
    check("t1 idle", 32'(ev.evt_valid), 32'd0);

    // 2: auto-repeat, key code 0x1, held 30 cycles
    n_log = 0;
    set_key(4'b0010, 4'b0001);
    kp_pressed = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ev.evt_valid && n_log < 8) begin
        log_t[n_log] = k;
        log_e[n_log] = head_word()[5:0];
        n_log++;
      end
      if (k == 29) kp_pressed = 1'b0;
    end
    check("t2 event count", 32'(n_log), 32'd5);
    check("t2 press t", 32'(log_t[0]), 32'd0);
    check("t2 press word", 32'(log_e[0]), 32'h01);
    check("t2 rep1 t", 32'(log_t[1]), 32'd15);
    check("t2 rep1 word", 32'(log_e[1]), 32'h21);
    check("t2 rep2 t", 32'(log_t[2]), 32'd20);
    check("t2 rep3 t", 32'(log_t[3]), 32'd25);
    check("t2 rep3 word", 32'(log_e[3]), 32'h21);
    check("t2 release t", 32'(log_t[4]), 32'd30);
    check("t2 release word", 32'(log_e[4]), 32'h11);
    ev.evt_ready = 1'b0;
    tick();

    // 3: consumer stalled, 5 pairs -> 8 stored, overflow; clear coincident with drop holds
    press_release(4'b0001, 4'b0001, 2, 2); exp_q.push_back(6'h00); exp_q.push_back(6'h10);
    press_release(4'b0010, 4'b0100, 2, 2); exp_q.push_back(6'h09); exp_q.push_back(6'h19);
    press_release(4'b1000, 4'b1000, 2, 2); exp_q.push_back(6'h0F); exp_q.push_back(6'h1F);
    press_release(4'b0100, 4'b0001, 2, 2); exp_q.push_back(6'h02); exp_q.push_back(6'h12);
    check("t3 no overflow at full", 32'(overflow), 32'd0);
    set_key(4'b0001, 4'b1000);
    kp_pressed = 1'b1;
    tick();
    check("t3 press dropped", 32'(overflow), 32'd1);
    tick();
    kp_pressed = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3 clr vs drop", 32'(overflow), 32'd1);
    tick();
    check("t3 head hold", head_word(), 32'h00);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3 ovf cleared", 32'(overflow), 32'd0);
    drain("t3");

    // 4: full FIFO, rise coincident with pop -> accepted, no overflow
    press_release(4'b0001, 4'b0001, 2, 2); exp_q.push_back(6'h00); exp_q.push_back(6'h10);
    press_release(4'b0010, 4'b0100, 2, 2); exp_q.push_back(6'h09); exp_q.push_back(6'h19);
    press_release(4'b1000, 4'b1000, 2, 2); exp_q.push_back(6'h0F); exp_q.push_back(6'h1F);
    press_release(4'b0100, 4'b0001, 2, 2); exp_q.push_back(6'h02); exp_q.push_back(6'h12);
    set_key(4'b0100, 4'b0010);
    kp_pressed = 1'b1;
    ev.evt_ready = 1'b1;
    tick();
    ev.evt_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(6'h06);
    check("t4 overflow", 32'(overflow), 32'd0);
    check("t4 head after pop", head_word(), 32'h10);
    drain("t4");
    kp_pressed = 1'b0;
    tick();
    exp_q.push_back(6'h16);
    drain("t4 rel");

    // 5: non-one-hot row -> bad_key pulse, no events
    set_key(4'b0001, 4'b0110);
    kp_pressed = 1'b1;
    tick();
    check("t5 bad_key", 32'(bad_key), 32'd1);
    check("t5 no press", 32'(ev.evt_valid), 32'd0);
    tick();
    check("t5 pulse ends", 32'(bad_key), 32'd0);
    kp_pressed = 1'b0;
    repeat (2) tick();
    check("t5 no release", 32'(ev.evt_valid), 32'd0);

    // 6: reset while held with 3 queued; no release afterwards, fresh press works
    press_release(4'b0001, 4'b0001, 2, 2);
    set_key(4'b0010, 4'b0100);
    kp_pressed = 1'b1;
    repeat (2) tick();
    check("t6 queued", 32'(ev.evt_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6 rst valid", 32'(ev.evt_valid), 32'd0);
    kp_pressed = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6 no release", 32'(ev.evt_valid), 32'd0);
    set_key(4'b1000, 4'b1000);
    kp_pressed = 1'b1;
    tick();
    exp_q.push_back(6'h0F);
    drain("t6 fresh");
    kp_pressed = 1'b0;
    tick();
    exp_q.push_back(6'h1F);
    drain("t6 fresh rel");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
